// File: rtl/resultado_lock_if.sv
// Digit/check request and door/lockout result bundle for resultado_lock.
// master drives the entered code and check; slave is the lock result stage.
interface resultado_lock_if;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned CNT_W   = 3;

  logic [DIGIT_W-1:0] m0;
  logic [DIGIT_W-1:0] m1;
  logic [DIGIT_W-1:0] m2;
  logic [DIGIT_W-1:0] m3;
  logic [DIGIT_W-1:0] m4;
  logic [DIGIT_W-1:0] m5;
  logic [LEN_W-1:0]   d;
  logic               check;
  logic               porta;
  logic               fail;
  logic               locked;
  logic [CNT_W-1:0]   fail_cnt;

  modport master (
    output m0, m1, m2, m3, m4, m5, d, check,
    input  porta, fail, locked, fail_cnt
  );

  modport slave (
    input  m0, m1, m2, m3, m4, m5, d, check,
    output porta, fail, locked, fail_cnt
  );
endinterface

// File: rtl/resultado_lock.sv
// Combination-lock result stage: code compare, timed door open, failure counting.
// Optional lockout after MAX_FAIL consecutive failures: define RESULTADO_LOCKOUT_EN.
module resultado_lock #(
  parameter logic [23:0] SECRET      = 24'h171717,
  parameter int unsigned OPEN_CYCLES = 16,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 64
) (
  input logic             clk,
  input logic             rst,
  resultado_lock_if.slave bus
);
  localparam int unsigned DIGITS  = 6;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned TMR_W   = 16;

  localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES);
`ifdef RESULTADO_LOCKOUT_EN
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES);
`endif

  // Timer is 16 bits and both periods must be non-zero.
  if (OPEN_CYCLES == 0 || OPEN_CYCLES > 65535 || MAX_FAIL == 0 ||
      LOCK_CYCLES == 0 || LOCK_CYCLES > 65535) begin : g_bad_cfg
    $error("resultado_lock: OPEN_CYCLES/LOCK_CYCLES must be 1..65535, MAX_FAIL >= 1");
  end

`ifdef RESULTADO_LOCKOUT_EN
  typedef enum logic [1:0] {IDLE, OPEN, LOCK} state_t;
`else
  typedef enum logic [0:0] {IDLE, OPEN} state_t;
`endif

  state_t             state, state_nx;
  logic [TMR_W-1:0]   timer, timer_nx;
  logic               porta_q, porta_nx;
  logic               fail_q, fail_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  logic [CNT_W-1:0]   cnt_inc;
  logic [DIGIT_W-1:0] digit [DIGITS];
  logic [LEN_W-1:0]   len_c;
  logic               match_c;

  assign digit[0] = bus.m0;
  assign digit[1] = bus.m1;
  assign digit[2] = bus.m2;
  assign digit[3] = bus.m3;
  assign digit[4] = bus.m4;
  assign digit[5] = bus.m5;

  // Compare the first len_c digits; a length of 7 only has six digits to check.
  always_comb begin
    len_c   = (bus.d == LEN_W'(7)) ? LEN_W'(6) : bus.d;
    match_c = (len_c != '0);
    for (int k = 0; k < DIGITS; k++) begin
      if (LEN_W'(k) < len_c) begin
        if (digit[k] != SECRET[DIGIT_W*k +: DIGIT_W] || digit[k] > DIGIT_W'(9)) begin
          match_c = 1'b0;
        end
      end
    end
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef RESULTADO_LOCKOUT_EN
  logic locked_q, locked_nx;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    porta_nx  = porta_q;
    fail_nx   = 1'b0;
    cnt_nx    = cnt_q;
`ifdef RESULTADO_LOCKOUT_EN
    locked_nx = locked_q;
`endif
    case (state)
      IDLE: begin
        if (bus.check) begin
          if (match_c) begin
            state_nx = OPEN;
            porta_nx = 1'b1;
            cnt_nx   = '0;
            timer_nx = OPEN_LOAD;
          end else begin
            fail_nx = 1'b1;
            cnt_nx  = cnt_inc;
`ifdef RESULTADO_LOCKOUT_EN
            if (32'(cnt_inc) >= MAX_FAIL) begin
              state_nx  = LOCK;
              locked_nx = 1'b1;
              timer_nx  = LOCK_LOAD;
            end
`endif
          end
        end
      end
      OPEN: begin
        if (timer <= TMR_W'(1)) begin
          state_nx = IDLE;
          porta_nx = 1'b0;
          timer_nx = '0;
        end else begin
          timer_nx = timer - TMR_W'(1);
        end
      end
`ifdef RESULTADO_LOCKOUT_EN
      LOCK: begin
        if (timer <= TMR_W'(1)) begin
          state_nx  = IDLE;
          locked_nx = 1'b0;
          cnt_nx    = '0;
          timer_nx  = '0;
        end else begin
          timer_nx = timer - TMR_W'(1);
        end
      end
`endif
      default: begin
        state_nx = IDLE;
        porta_nx = 1'b0;
        timer_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      porta_q  <= 1'b0;
      fail_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef RESULTADO_LOCKOUT_EN
      locked_q <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      porta_q  <= porta_nx;
      fail_q   <= fail_nx;
      cnt_q    <= cnt_nx;
`ifdef RESULTADO_LOCKOUT_EN
      locked_q <= locked_nx;
`endif
    end
  end

  assign bus.porta    = porta_q;
  assign bus.fail     = fail_q;
  assign bus.fail_cnt = cnt_q;
`ifdef RESULTADO_LOCKOUT_EN
  assign bus.locked   = locked_q;
`else
  assign bus.locked   = 1'b0;
`endif
endmodule

// File: tb/tb_resultado_lock.sv
// Scoreboard bench for resultado_lock: stimulus queues expected door/fail/unlock
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_resultado_lock;
  localparam int OPEN_CYCLES = 16;
  localparam int LOCK_CYCLES = 64;
  // Digit k of a code sits in bits [4k+3:4k]; the secret 24'h171717 means m0=7, m1=1, ...
  localparam logic [23:0] GOOD = 24'h171717;

  logic clk;
  logic rst;
  resultado_lock_if bus();

  resultado_lock dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {EV_OPEN, EV_FAIL, EV_CLOSE, EV_UNLOCK} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [5:0] sig;   // {porta, fail, locked, fail_cnt}
    int         len;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic push(input ev_kind_e k, input logic [5:0] s, input int l);
    ev_t e;
    e.kind = k;
    e.sig  = s;
    e.len  = l;
    q.push_back(e);
  endtask

  task automatic push_open();
    push(EV_OPEN, {1'b1, 1'b0, 1'b0, 3'd0}, 0);
  endtask
  task automatic push_close();
    push(EV_CLOSE, 6'd0, OPEN_CYCLES);
  endtask
  task automatic push_fail(input logic [2:0] cnt, input logic lk);
    push(EV_FAIL, {1'b0, 1'b1, lk, cnt}, 0);
  endtask
  task automatic push_unlock();
    push(EV_UNLOCK, 6'd0, LOCK_CYCLES);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_event(input ev_kind_e k, input logic [5:0] s, input int l);
    ev_t e;
    logic ok;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got sig=%b len=%0d, want no event", k.name(), s, l);
    end else begin
      e  = q.pop_front();
      ok = (e.kind == k);
      case (k)
        EV_OPEN, EV_FAIL: ok = ok && (s == e.sig);
        EV_CLOSE:         ok = ok && (l == e.len);
        EV_UNLOCK:        ok = ok && (s[2:0] == 3'd0) && (l == e.len);
        default:          ok = 1'b0;
      endcase
      if (!ok) begin
        errors++;
        $display("FAIL event_%s: got kind=%s sig=%b len=%0d, want kind=%s sig=%b len=%0d",
                 k.name(), k.name(), s, l, e.kind.name(), e.sig, e.len);
      end
    end
  endtask

  // Monitor: detect door rise/fall, fail pulses and lock release.
  logic porta_p  = 1'b0;
  logic locked_p = 1'b0;
  int   open_len = 0;
  int   lock_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      porta_p  = 1'b0;
      locked_p = 1'b0;
      open_len = 0;
      lock_len = 0;
    end else begin
      if (bus.porta)  open_len = porta_p ? open_len + 1 : 1;
      if (bus.locked) lock_len = locked_p ? lock_len + 1 : 1;
      if (bus.porta && !porta_p)
        check_event(EV_OPEN, {bus.porta, bus.fail, bus.locked, bus.fail_cnt}, 0);
      if (bus.fail)
        check_event(EV_FAIL, {bus.porta, bus.fail, bus.locked, bus.fail_cnt}, 0);
      if (!bus.porta && porta_p)
        check_event(EV_CLOSE, {bus.porta, bus.fail, bus.locked, bus.fail_cnt}, open_len);
      if (!bus.locked && locked_p)
        check_event(EV_UNLOCK, {bus.porta, bus.fail, bus.locked, bus.fail_cnt}, lock_len);
      porta_p  = bus.porta;
      locked_p = bus.locked;
    end
  end

  task automatic drive(input logic [23:0] code, input logic [2:0] dd, input int hold);
    @(negedge clk);
    bus.m0 = code[3:0];
    bus.m1 = code[7:4];
    bus.m2 = code[11:8];
    bus.m3 = code[15:12];
    bus.m4 = code[19:16];
    bus.m5 = code[23:20];
    bus.d  = dd;
    bus.check = 1'b1;
    repeat (hold) @(negedge clk);
    bus.check = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got %0d pending events, want 0", name, q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Raise rst between edges and confirm outputs clear without a clock.
  task automatic async_reset(input string name);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk({name, "_porta"}, int'(bus.porta), 0);
    chk({name, "_locked"}, int'(bus.locked), 0);
    chk({name, "_fail_cnt"}, int'(bus.fail_cnt), 0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b0;
    bus.m0 = '0; bus.m1 = '0; bus.m2 = '0; bus.m3 = '0; bus.m4 = '0; bus.m5 = '0;
    bus.d = '0;
    bus.check = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset_porta", int'(bus.porta), 0);
    chk("reset_fail", int'(bus.fail), 0);
    chk("reset_locked", int'(bus.locked), 0);
    chk("reset_fail_cnt", int'(bus.fail_cnt), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full code opens; a wrong check while open is ignored.
    push_open(); push_close();
    drive(GOOD, 3'd6, 1);
    repeat (3) @(negedge clk);
    drive(24'h000000, 3'd6, 1);
    drain("full_code", 200);

    // Short code: only m0, m1 compared.
    push_open(); push_close();
    drive(24'h000017, 3'd2, 1);
    drain("short_code", 200);

    // Length 7 behaves as 6.
    push_open(); push_close();
    drive(GOOD, 3'd7, 1);
    drain("len7", 200);

    // Wrong digit 3, then zero length, then invalid digit.
    push_fail(3'd1, 1'b0);
    drive(24'h178717, 3'd6, 1);
    drain("wrong_m3", 50);
    push_fail(3'd2, 1'b0);
    drive(GOOD, 3'd0, 1);
    drain("len0", 50);

`ifdef RESULTADO_LOCKOUT_EN
    push_fail(3'd3, 1'b1);
    drive(24'h17171F, 3'd1, 1);
    drive(GOOD, 3'd6, 1);            // ignored while locked
    push_unlock();
    drain("lockout", 300);
    push_open(); push_close();
    drive(GOOD, 3'd6, 1);
    drain("after_unlock", 200);
    // Level-sensitive check held two cycles, then a third failure locks again.
    push_fail(3'd1, 1'b0); push_fail(3'd2, 1'b0);
    drive(24'h000000, 3'd4, 2);
    push_fail(3'd3, 1'b1);
    drive(24'h000000, 3'd4, 1);
    drain("relock", 50);
    async_reset("reset_mid_lock");
`else
    push_fail(3'd3, 1'b0);
    drive(24'h17171F, 3'd1, 1);
    push_fail(3'd4, 1'b0);
    drive(24'h000000, 3'd3, 1);
    push_fail(3'd5, 1'b0);
    drive(24'h17171A, 3'd1, 1);
    drain("five_wrong", 50);
    chk("five_wrong_fail_cnt", int'(bus.fail_cnt), 5);
    chk("five_wrong_locked", int'(bus.locked), 0);
    // Level-sensitive check held three cycles; counter saturates at 7.
    push_fail(3'd6, 1'b0); push_fail(3'd7, 1'b0); push_fail(3'd7, 1'b0);
    drive(24'h000000, 3'd6, 3);
    drain("saturate", 50);
    push_open(); push_close();
    drive(GOOD, 3'd6, 1);
    drain("open_after_fails", 200);
    push_fail(3'd1, 1'b0);
    drive(24'h000000, 3'd1, 1);
    drain("pre_reset_fail", 50);
    async_reset("reset_with_count");
`endif

    // Reset while the door is open drops porta at once.
    push_open();
    drive(GOOD, 3'd6, 1);
    drain("open_for_reset", 50);
    async_reset("reset_mid_open");
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
